// File: rtl/fsmseq_gen_if.sv
// fsmseq_gen_if: control and serial-output bundle of the pattern generator.
interface fsmseq_gen_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int REP_W = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [REP_W-1:0] rep;
    logic             x_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic [3:0]       state_out;
    modport master (
        output start, abort, pattern, len, rep,
        input  x_out, bit_valid, busy, done, err, state_out
    );
    modport slave (
        input  start, abort, pattern, len, rep,
        output x_out, bit_valid, busy, done, err, state_out
    );
endinterface

// File: rtl/fsmseq_gen.sv
// fsmseq_gen: serial pattern generator, MSB-first, with repetitions and zero gaps.
module fsmseq_gen #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int GAP   = 2,
    parameter int REP_W = 4
) (
    input logic         clk,
    input logic         reset,
    fsmseq_gen_if.slave bus
);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    typedef enum logic [2:0] {IDLE = 3'd0, SHIFT = 3'd1, GAPS = 3'd2, DONE = 3'd3} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] pat, pat_d;
    logic [LEN_W-1:0] len_q, len_d, bit_cnt, bit_d;
    logic [REP_W-1:0] rep_cnt, rep_d;
    logic [GW-1:0]    gap_cnt, gap_d;
    logic             err_q, err_d;
    logic             len_ok;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pat     <= '0;
            len_q   <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            pat     <= pat_d;
            len_q   <= len_d;
            bit_cnt <= bit_d;
            rep_cnt <= rep_d;
            gap_cnt <= gap_d;
            err_q   <= err_d;
        end
    end
    // counters only ever count down to zero and are reloaded, so nothing wraps
    always_comb begin
        len_ok  = bus.len != '0 && bus.len <= LEN_W'(WIDTH);
        state_d = state;
        pat_d   = pat;
        len_d   = len_q;
        bit_d   = bit_cnt;
        rep_d   = rep_cnt;
        gap_d   = gap_cnt;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && len_ok) begin
                    state_d = SHIFT;
                    pat_d   = bus.pattern;
                    len_d   = bus.len;
                    bit_d   = bus.len - 1'b1;
                    rep_d   = bus.rep;
                end
                err_d = bus.start && !len_ok;
            end
            SHIFT: begin
                if (bus.abort) state_d = IDLE;
                else if (bit_cnt != '0) bit_d = bit_cnt - 1'b1;
                else if (rep_cnt == '0) state_d = DONE;
                else begin
                    rep_d   = rep_cnt - 1'b1;
                    bit_d   = len_q - 1'b1;
                    state_d = GAP > 0 ? GAPS : SHIFT;
                    gap_d   = GW'(GAP > 0 ? GAP - 1 : 0);
                end
            end
            GAPS: begin
                if (bus.abort) state_d = IDLE;
                else if (gap_cnt == '0) state_d = SHIFT;
                else gap_d = gap_cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.bit_valid = state == SHIFT;
        bus.x_out     = state == SHIFT && |(pat & (WIDTH'(1) << bit_cnt));
        bus.busy      = state != IDLE;
        bus.done      = state == DONE;
        bus.err       = err_q;
        bus.state_out = {1'b0, state};
    end
endmodule

// File: tb/tb_fsmseq_gen.sv
// tb_fsmseq_gen: vector table plus scoreboard of per-cycle expected outputs.
module tb_fsmseq_gen;
    typedef struct packed {
        logic x; logic v; logic busy; logic done; logic err; logic [3:0] st;
    } out_t;
    typedef struct {
        logic [15:0] pat; int len; int rep; int dut; int poke; int abt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    out_t q[$];
    vec_t tv[12];

    fsmseq_gen_if ia();
    fsmseq_gen_if ib();
    fsmseq_gen u_a (.clk(clk), .reset(reset), .bus(ia));
    fsmseq_gen #(.GAP(0)) u_b (.clk(clk), .reset(reset), .bus(ib));

    always #5 clk = ~clk;

    function automatic out_t mk(input logic x, v, b, dn, er, input logic [3:0] st);
        out_t o;
        o.x = x; o.v = v; o.busy = b; o.done = dn; o.err = er; o.st = st;
        return o;
    endfunction

    function automatic out_t obs(input int d);
        out_t o;
        o = d != 0 ? {ib.x_out, ib.bit_valid, ib.busy, ib.done, ib.err, ib.state_out}
                   : {ia.x_out, ia.bit_valid, ia.busy, ia.done, ia.err, ia.state_out};
        return o;
    endfunction

    task automatic check(input string nm, input int cyc, input out_t a, input out_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s cycle %0d: got x,v,busy,done,err,st=%b expected %b", nm, cyc, a, e);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic set_in(input int d, input logic st, input logic [15:0] pat,
                          input logic [4:0] ln, input logic [3:0] rp, input logic ab);
        ia.start = st && d == 0; ib.start = st && d == 1;
        ia.pattern = pat; ib.pattern = pat;
        ia.len = ln; ib.len = ln;
        ia.rep = rp; ib.rep = rp;
        ia.abort = ab; ib.abort = ab;
    endtask

    // expected per-cycle outputs from cycle 1 to the first idle cycle after the run
    task automatic push_tx(input logic [15:0] pat, input int ln, input int rp, input int gp);
        if (ln < 1 || ln > 16) q.push_back(mk(0, 0, 0, 0, 1, 4'd0));
        else begin
            for (int r = 0; r <= rp; r++) begin
                for (int k = ln - 1; k >= 0; k--) q.push_back(mk(pat[k], 1, 1, 0, 0, 4'd1));
                if (r < rp) for (int g = 0; g < gp; g++) q.push_back(mk(0, 0, 1, 0, 0, 4'd2));
            end
            q.push_back(mk(0, 0, 1, 1, 0, 4'd3));
        end
        q.push_back(mk(0, 0, 0, 0, 0, 4'd0));
    endtask

    task automatic run(input vec_t t, input string nm);
        int   cyc, nd;
        out_t a, e;
        logic pk;
        cyc = 1; nd = 0;
        push_tx(t.pat, t.len, t.rep, t.dut != 0 ? 0 : 2);
        set_in(t.dut, 1'b1, t.pat, t.len[4:0], t.rep[3:0], t.abt == 0);
        @(posedge clk); #1;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = obs(t.dut);
            if (a.done) nd++;
            check(nm, cyc, a, e);
            if (q.size() > 0) begin
                pk = cyc == t.poke;
                set_in(t.dut, pk, ~t.pat, pk ? 5'd0 : t.len[4:0], ~t.rep[3:0], cyc == t.abt);
                @(posedge clk); #1;
                cyc++;
            end
        end
        set_in(t.dut, 1'b0, 16'h0, 5'd0, 4'd0, 1'b0);
        check_int({nm, " done count"}, nd, (t.len < 1 || t.len > 16) ? 0 : 1);
    endtask

    initial begin
        out_t a;
        int   nd;
        tv[0]  = '{16'h000B, 4, 1, 0, -1, 0};
        tv[1]  = '{16'h0005, 3, 2, 1, -1, -1};
        tv[2]  = '{16'h1234, 0, 0, 0, -1, -1};
        tv[3]  = '{16'h1234, 17, 0, 0, -1, -1};
        tv[4]  = '{16'h1234, 31, 3, 1, -1, -1};
        tv[5]  = '{16'h8001, 16, 15, 0, -1, -1};
        tv[6]  = '{16'h000B, 4, 1, 0, 3, -1};
        tv[7]  = '{16'h000B, 4, 1, 0, 11, 11};
        tv[8]  = '{16'hABCD, 16, 0, 1, -1, -1};
        tv[9]  = '{16'h0001, 1, 0, 0, -1, -1};
        tv[10] = '{16'h0002, 1, 3, 0, -1, -1};
        tv[11] = '{16'hFFFF, 16, 15, 1, -1, -1};
        set_in(0, 1'b0, 16'h0, 5'd0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset a", 0, obs(0), mk(0, 0, 0, 0, 0, 4'd0));
        check("reset b", 0, obs(1), mk(0, 0, 0, 0, 0, 4'd0));
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) run(tv[i], $sformatf("vec%0d", i));
        // abort in the third bit of a len=8 transmission
        set_in(0, 1'b1, 16'h00A5, 5'd8, 4'd0, 1'b0);
        @(posedge clk); #1;
        ia.start = 1'b0;
        check("abort", 1, obs(0), mk(1, 1, 1, 0, 0, 4'd1));
        @(posedge clk); #1;
        check("abort", 2, obs(0), mk(0, 1, 1, 0, 0, 4'd1));
        @(posedge clk); #1;
        check("abort", 3, obs(0), mk(1, 1, 1, 0, 0, 4'd1));
        ia.abort = 1'b1;
        @(posedge clk); #1;
        ia.abort = 1'b0;
        check("abort", 4, obs(0), mk(0, 0, 0, 0, 0, 4'd0));
        nd = 0;
        repeat (15) begin
            @(posedge clk); #1;
            a = obs(0);
            if (a.done) nd++;
        end
        check_int("abort done count", nd, 0);
        // asynchronous reset in cycle 5 of a transmission
        set_in(0, 1'b1, 16'hFFFF, 5'd16, 4'd0, 1'b0);
        @(posedge clk); #1;
        ia.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst", 5, obs(0), mk(1, 1, 1, 0, 0, 4'd1));
        reset = 1'b1;
        #1;
        check("midrst async", 5, obs(0), mk(0, 0, 0, 0, 0, 4'd0));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        nd = 0;
        repeat (20) begin
            @(posedge clk); #1;
            a = obs(0);
            if (a.done) nd++;
        end
        check_int("midrst done count", nd, 0);
        check("midrst idle", 0, obs(0), mk(0, 0, 0, 0, 0, 4'd0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
